// File: rtl/pwm_dac_out.sv
// Single-pin PWM DAC: one offset-binary sample per 2^WIDTH-count frame.
// A staging register takes samples via valid/ready; the duty only changes at frame boundaries.
module pwm_dac_out #(
    parameter int unsigned WIDTH      = 10,
    parameter int unsigned PRESCALE   = 1,
    parameter int unsigned RESET_DUTY = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] sample_data,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             pwm_out,
    output logic             frame_start,
    output logic             underrun,
    input  logic             underrun_clr
);
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_LAST = {WIDTH{1'b1}};

    logic [PW-1:0]    r_pre;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_duty;
    logic [WIDTH-1:0] r_staged;
    logic             r_empty;
    logic             r_pwm;
    logic             r_fs;
    logic             r_und;

    logic w_tick;
    logic w_boundary;
    logic w_accept;

    assign w_tick     = enable && (r_pre == PRE_LAST);
    assign w_boundary = w_tick && (r_cnt == CNT_LAST);
    assign w_accept   = sample_valid && r_empty;

    // Prescaler and PWM counter; both held at zero while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else if (!enable) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
            r_cnt <= r_cnt + WIDTH'(1);
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    // Staging register: an empty boundary leaves room for a same-cycle accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty   <= WIDTH'(RESET_DUTY);
            r_staged <= '0;
            r_empty  <= 1'b1;
        end else if (w_boundary && !r_empty) begin
            r_duty  <= r_staged;
            r_empty <= 1'b1;
        end else if (w_accept) begin
            r_staged <= sample_data;
            r_empty  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= 1'b0;
            r_fs  <= 1'b0;
            r_und <= 1'b0;
        end else begin
            r_pwm <= enable && (r_cnt < r_duty);
            r_fs  <= w_boundary;
            if (w_boundary && r_empty) begin
                r_und <= 1'b1;
            end else if (underrun_clr) begin
                r_und <= 1'b0;
            end
        end
    end

    assign sample_ready = r_empty;
    assign pwm_out      = r_pwm;
    assign frame_start  = r_fs;
    assign underrun     = r_und;

endmodule
